// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer between the ALU and write-back.
// Holds result, destination, flags and a pre-resolved branch decision for each
// entry, and keeps a saturating count of accepted overflow results.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALU_OUT,
  input  logic              carry,
  input  logic              zero,
  input  logic              negative,
  input  logic              overflow,
  input  logic              underflow,
  input  logic [4:0]        rd,
  input  logic              wb_en,
  input  logic [2:0]        br_type,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_rd,
  output logic              out_wb_en,
  output logic [4:0]        out_flags,
  output logic              branch_taken,
  output logic [CNT_W-1:0]  ovf_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic [CNT_W-1:0]    r_ovf_count;

  // Head entry drives the outputs directly; skid entry is the younger one.
  logic [DATA_W-1:0]   r_h_data;
  logic [4:0]          r_h_rd;
  logic                r_h_wb;
  logic [4:0]          r_h_flags;
  logic                r_h_taken;
  logic [DATA_W-1:0]   r_s_data;
  logic [4:0]          r_s_rd;
  logic                r_s_wb;
  logic [4:0]          r_s_flags;
  logic                r_s_taken;

  logic                w_push;
  logic                w_pop;
  logic                w_head_from_in;
  logic                w_head_from_skid;
  logic                w_skid_we;
  logic                w_taken;
  logic                w_wb;
  logic [4:0]          w_flags;

  // Branch decision from the ALU flags; BLT/BGE family relies on the ALU
  // placing the comparison result in bit 0.
  function automatic logic resolve_branch(input logic [2:0] bt, input logic z,
                                          input logic lsb);
    case (bt)
      3'd1:       return z;
      3'd2:       return ~z;
      3'd3, 3'd5: return lsb;
      3'd4, 3'd6: return ~lsb;
      default:    return 1'b0;
    endcase
  endfunction

  // Branches never write back, and neither does a write to x0.
  function automatic logic resolve_wb(input logic en, input logic [2:0] bt,
                                      input logic [4:0] idx);
    return en && !(bt >= 3'd1 && bt <= 3'd6) && (idx != 5'd0);
  endfunction

  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = (r_state != EMPTY) & out_ready;
  assign w_taken   = resolve_branch(br_type, zero, ALU_OUT[0]);
  assign w_wb      = resolve_wb(wb_en, br_type, rd);
  assign w_flags   = {carry, zero, negative, overflow, underflow};

  assign w_head_from_in   = !flush && w_push &&
                            ((r_state == EMPTY) || (r_state == ONE && w_pop));
  assign w_head_from_skid = !flush && (r_state == TWO) && w_pop;
  assign w_skid_we        = !flush && (r_state == ONE) && w_push && !w_pop;

  // Occupancy state and the registered ready; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        EMPTY: if (w_push) r_state <= ONE;
        ONE: begin
          if (w_push && !w_pop) begin
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_pop && !w_push) begin
            r_state <= EMPTY;
          end
        end
        TWO: begin
          if (w_pop) r_state <= ONE;
          else       r_in_ready <= 1'b0;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Head entry: loads a new capture or advances the skid entry forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_data  <= '0;
      r_h_rd    <= '0;
      r_h_wb    <= 1'b0;
      r_h_flags <= '0;
      r_h_taken <= 1'b0;
    end else if (w_head_from_in) begin
      r_h_data  <= ALU_OUT;
      r_h_rd    <= rd;
      r_h_wb    <= w_wb;
      r_h_flags <= w_flags;
      r_h_taken <= w_taken;
    end else if (w_head_from_skid) begin
      r_h_data  <= r_s_data;
      r_h_rd    <= r_s_rd;
      r_h_wb    <= r_s_wb;
      r_h_flags <= r_s_flags;
      r_h_taken <= r_s_taken;
    end
  end

  // Skid entry captures only when the head is occupied and not draining.
  always_ff @(posedge clk) begin
    if (w_skid_we) begin
      r_s_data  <= ALU_OUT;
      r_s_rd    <= rd;
      r_s_wb    <= w_wb;
      r_s_flags <= w_flags;
      r_s_taken <= w_taken;
    end
  end

  // Saturating count of accepted overflow results; flushed pushes don't count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (!flush && w_push && overflow && (r_ovf_count != '1)) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state != EMPTY);
  assign out_data     = r_h_data;
  assign out_rd       = r_h_rd;
  assign out_wb_en    = r_h_wb;
  assign out_flags    = r_h_flags;
  assign branch_taken = r_h_taken;
  assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based scoreboard of expected entries,
// directed scenarios plus a random phase. Counter width reduced to 4 bits.
module tb_alu_result_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CMAX   = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ALU_OUT;
  logic              carry, zero, negative, overflow, underflow;
  logic [4:0]        rd;
  logic              wb_en;
  logic [2:0]        br_type;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        out_rd;
  logic              out_wb_en;
  logic [4:0]        out_flags;
  logic              branch_taken;
  logic [CNT_W-1:0]  ovf_count;

  alu_result_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_OUT(ALU_OUT), .carry(carry), .zero(zero), .negative(negative),
    .overflow(overflow), .underflow(underflow), .rd(rd), .wb_en(wb_en),
    .br_type(br_type), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wb_en(out_wb_en), .out_flags(out_flags), .branch_taken(branch_taken),
    .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [4:0]        rd;
    logic              wb;
    logic [4:0]        fl;
    logic              tk;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;
  bit   mon_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t model(input logic [31:0] d, input logic [4:0] r,
                                 input logic w, input logic [4:0] fl,
                                 input logic [2:0] bt);
    ent_t e;
    logic z;
    z    = fl[3];
    e.d  = d;
    e.rd = r;
    e.fl = fl;
    e.wb = w && (r != 5'd0) && !(bt inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});
    case (bt)
      3'd1: e.tk = z;
      3'd2: e.tk = !z;
      3'd3, 3'd5: e.tk = d[0];
      3'd4, 3'd6: e.tk = !d[0];
      default: e.tk = 1'b0;
    endcase
    return e;
  endfunction

  // Scoreboard: at each falling edge compare DUT state against the queue,
  // then apply the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      logic mready, push, pop;
      ent_t h;
      mready = (q.size() < 2);
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, mready);
      chk("ovf_count", ovf_count, mcnt);
      if (q.size() != 0) begin
        h = q[0];
        chk("out_data", out_data, h.d);
        chk("out_rd", out_rd, h.rd);
        chk("out_wb_en", out_wb_en, h.wb);
        chk("out_flags", out_flags, h.fl);
        chk("branch_taken", branch_taken, h.tk);
      end
      push = in_valid && mready;
      pop  = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (flush) begin
        q.delete();
      end else if (push) begin
        q.push_back(model(ALU_OUT, rd, wb_en,
                          {carry, zero, negative, overflow, underflow}, br_type));
        if (overflow && mcnt < CMAX) mcnt++;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] r,
                       input logic w, input logic [4:0] fl, input logic [2:0] bt,
                       input logic fls);
    @(posedge clk);
    #1;
    in_valid = v; ALU_OUT = d; rd = r; wb_en = w; br_type = bt; flush = fls;
    {carry, zero, negative, overflow, underflow} = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 out_ready = r;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; ALU_OUT = 0; rd = 0; wb_en = 0; br_type = 0;
    flush = 0; out_ready = 0;
    {carry, zero, negative, overflow, underflow} = 5'd0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_wb_en", out_wb_en, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_branch_taken", branch_taken, 0);
    chk("rst_ovf_count", ovf_count, 0);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1 chk("rel_in_ready", in_ready, 1);
    mon_en = 1'b1;

    // Single pass with downstream ready
    out_ready = 1'b1;
    drive(1, 32'h5, 5'd3, 1, 5'd0, 3'd0, 0);
    idle(1);
    #3;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 32'h5);
    chk("single_rd", out_rd, 5'd3);
    chk("single_wb", out_wb_en, 1);
    idle(1);
    #3 chk("single_drained", out_valid, 0);

    // Backpressure: two captured, third ignored
    set_ready(0);
    drive(1, 32'hA, 5'd1, 1, 5'd0, 3'd0, 0);
    drive(1, 32'hB, 5'd2, 1, 5'd0, 3'd0, 0);
    drive(1, 32'hC, 5'd4, 1, 5'd0, 3'd0, 0);
    #3 chk("bp_in_ready", in_ready, 0);
    idle(2);
    #3 chk("bp_hold_data", out_data, 32'hA);
    out_ready = 1'b1;
    idle(1);
    #3 chk("bp_second", out_data, 32'hB);
    idle(1);
    #3 chk("bp_empty", out_valid, 0);

    // Branch resolution and write-back suppression
    drive(1, 32'h0, 5'd5, 1, 5'b01000, 3'd1, 0);
    idle(1);
    #3 chk("beq_taken", branch_taken, 1);
    chk("beq_wb", out_wb_en, 0);
    drive(1, 32'h1, 5'd6, 1, 5'd0, 3'd4, 0);
    idle(1);
    #3 chk("bge_taken", branch_taken, 0);
    drive(1, 32'h7, 5'd0, 1, 5'd0, 3'd7, 0);
    drive(1, 32'h1, 5'd9, 1, 5'd0, 3'd5, 0);
    idle(2);

    // Flush in TWO with a simultaneous push
    set_ready(0);
    drive(1, 32'h11, 5'd1, 1, 5'd0, 3'd0, 0);
    drive(1, 32'h22, 5'd2, 1, 5'd0, 3'd0, 0);
    drive(1, 32'hDEAD, 5'd3, 1, 5'b00010, 3'd0, 1);
    idle(1);
    #3 chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    idle(2);
    out_ready = 1'b1;

    // Counter saturation
    for (int i = 0; i < 20; i++) drive(1, 32'(i), 5'd7, 1, 5'b00010, 3'd0, 0);
    idle(2);
    #3 chk("ovf_sat", ovf_count, 4'd15);
    drive(0, 32'h0, 5'd0, 0, 5'b00010, 3'd0, 1);
    idle(1);
    #3 chk("ovf_after_flush", ovf_count, 4'd15);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1), 5'($urandom), 3'($urandom),
            ($urandom_range(0, 29) == 0));
    end
    idle(3);

    // Asynchronous reset while full
    out_ready = 1'b0;
    drive(1, 32'h33, 5'd1, 1, 5'b00010, 3'd0, 0);
    drive(1, 32'h44, 5'd2, 1, 5'b00010, 3'd0, 0);
    idle(1);
    #3 chk("pre_rst_full", in_ready, 0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_ovf_count", ovf_count, 0);
    chk("async_in_ready", in_ready, 0);
    q.delete();
    mcnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rerel_in_ready", in_ready, 1);
    mon_en = 1'b1;
    out_ready = 1'b1;
    drive(1, 32'h55, 5'd8, 1, 5'd0, 3'd0, 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
